// File: rtl/divider_unit.sv
// divider_unit -- iterative 32-bit integer divider for the RISC-V M ops
// DIV, DIVU, REM and REMU.
//
// It runs radix-2 restoring division on operand magnitudes and produces one
// quotient bit per cycle. A request sampled in cycle N delivers its result
// with a one-cycle done pulse in cycle N+33. Divide-by-zero and the signed
// overflow case (0x80000000 / -1) return the fixed RISC-V results.
//
// Optional feature: define DIV_SPECIAL_FAST_EN to make those special cases
// skip the iteration and go IDLE->DONE, so done arrives in cycle N+1. The
// results are the same in both builds.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous reset, active low
//   start     in   request strobe; only sampled in IDLE
//   op        in   00=DIV 01=DIVU 10=REM 11=REMU
//   rd_in     in   destination register of the request
//   dividend  in   rs1 value
//   divisor   in   rs2 value
//   busy      out  high whenever the unit is not IDLE
//   done      out  one-cycle pulse; result/rd_out are valid in that cycle
//   rd_out    out  captured rd; holds until the next DONE cycle
//   result    out  quotient or remainder; holds until the next DONE cycle
module divider_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic [4:0]      cnt;
    logic [XLEN-1:0] dvd_q;      // original dividend, returned by REM x/0
    logic [XLEN-1:0] dvs_mag;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;      // starts as |dividend|, shifts into quotient
    logic            qneg_q, rneg_q, dz_q, ovf_q;

    // Request decode (only meaningful while IDLE)
    logic            in_signed, a_neg, b_neg, in_dz, in_ovf, fast_go;
    logic [XLEN-1:0] a_mag, b_mag;

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & dividend[XLEN-1];
    assign b_neg     = in_signed & divisor[XLEN-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor  : divisor;
    assign in_dz     = (divisor == '0);
    assign in_ovf    = in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                                 && (divisor == '1);

`ifdef DIV_SPECIAL_FAST_EN
    assign fast_go = in_dz | in_ovf;
`else
    assign fast_go = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The borrow bit of the
    // (XLEN+1)-bit difference says whether it did.
    logic [XLEN:0]   step_t, step_sub;
    logic            step_ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt;

    assign step_t   = {rem_q, quo_q[XLEN-1]};
    assign step_sub = step_t - {1'b0, dvs_mag};
    assign step_ge  = ~step_sub[XLEN];
    assign rem_nxt  = step_ge ? step_sub[XLEN-1:0] : step_t[XLEN-1:0];
    assign quo_nxt  = {quo_q[XLEN-2:0], step_ge};

    // Final result selection: the special cases override the datapath, and
    // otherwise the signs are restored onto the magnitudes.
    function automatic logic [XLEN-1:0] fixup(
        input logic [1:0]      f_op,
        input logic [XLEN-1:0] f_dvd,
        input logic            f_dz,
        input logic            f_ovf,
        input logic [XLEN-1:0] f_q,
        input logic [XLEN-1:0] f_r,
        input logic            f_qneg,
        input logic            f_rneg
    );
        logic [XLEN-1:0] r;
        if (f_dz)
            r = f_op[1] ? f_dvd : '1;
        else if (f_ovf)
            r = f_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (f_op[1])
            r = f_rneg ? -f_r : f_r;
        else
            r = f_qneg ? -f_q : f_q;
        return r;
    endfunction

    logic [XLEN-1:0] calc_res, fast_res;

    assign calc_res = fixup(op_q, dvd_q, dz_q, ovf_q, quo_nxt, rem_nxt, qneg_q, rneg_q);
    assign fast_res = fixup(op, dividend, in_dz, in_ovf, '0, '0, 1'b0, 1'b0);

    // FSM
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast_go ? DONE : CALC;
            CALC:    if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            result  <= '0;
            rd_out  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            dvd_q   <= '0;
            dvs_mag <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q    <= op;
                    rd_q    <= rd_in;
                    dvd_q   <= dividend;
                    dvs_mag <= b_mag;
                    rem_q   <= '0;
                    quo_q   <= a_mag;
                    qneg_q  <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    dz_q    <= in_dz;
                    ovf_q   <= in_ovf;
                    cnt     <= '0;
                    if (fast_go) begin
                        result <= fast_res;
                        rd_out <= rd_in;
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + 5'd1;
                    // The last step's result is written on the way into DONE.
                    if (cnt == 5'd31) begin
                        result <= calc_res;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  rd_in;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIV_SPECIAL_FAST_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    divider_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rd_in    (rd_in),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .rd_out   (rd_out),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done. With inject set, a second
    // start with different operands is pulsed ten cycles in; it must be ignored.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat, input bit inject);
        int   lat;
        logic busy_ok;
        logic [31:0] res_seen;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'b00; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd7;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            start = inject && (lat == 10);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (!busy) busy_ok = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        res_seen = result;
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " hold"}, res_seen, exp_res);
    endtask

    initial begin
        int dones;
        logic busy_seen;
        rst = 1'b0; start = 1'b0; op = '0; rd_in = '0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy",   {31'd0, busy}, 32'd0);
        chk("rst done",   {31'd0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk) rst = 1'b1;

        run_op("div -7/2",       2'b00, 32'hFFFF_FFF9, 32'd2,        5'd1,  32'hFFFF_FFFD, 33, 0);
        run_op("rem -7/2",       2'b10, 32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFF, 33, 0);
        run_op("divu 100/7",     2'b01, 32'd100,       32'd7,        5'd9,  32'h0000_000E, 33, 0);
        run_op("remu 100/7",     2'b11, 32'd100,       32'd7,        5'd17, 32'h0000_0002, 33, 0);
        run_op("div 7/-2",       2'b00, 32'd7,         32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 33, 0);
        run_op("rem 7/-2",       2'b10, 32'd7,         32'hFFFF_FFFE, 5'd5, 32'h0000_0001, 33, 0);
        run_op("rem -7/-2",      2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFF, 33, 0);
        run_op("divu max/1",     2'b01, 32'hFFFF_FFFF, 32'd1,        5'd31, 32'hFFFF_FFFF, 33, 0);
        run_op("divu 8000/ffff", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, 33, 0);
        run_op("remu 8000/ffff", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 33, 0);
        run_op("rd x0",          2'b01, 32'd9,         32'd3,        5'd0,  32'h0000_0003, 33, 0);
        run_op("div 5/0",        2'b00, 32'd5,         32'd0,        5'd10, 32'hFFFF_FFFF, SP_LAT, 0);
        run_op("rem 5/0",        2'b10, 32'd5,         32'd0,        5'd11, 32'h0000_0005, SP_LAT, 0);
        run_op("divu x/0",       2'b01, 32'hDEAD_BEEF, 32'd0,        5'd12, 32'hFFFF_FFFF, SP_LAT, 0);
        run_op("remu x/0",       2'b11, 32'hDEAD_BEEF, 32'd0,        5'd13, 32'hDEAD_BEEF, SP_LAT, 0);
        run_op("div ovf",        2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, SP_LAT, 0);
        run_op("rem ovf",        2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, SP_LAT, 0);
        run_op("busy ignore",    2'b01, 32'd100,       32'd7,        5'd3,  32'h0000_000E, 33, 1);

        // Reset in the middle of an operation, with a start ignored while busy
        // and another start coincident with reset.
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd_in = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        chk("midrst busy",   {31'd0, busy}, 32'd0);
        chk("midrst done",   {31'd0, done}, 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst rd_out", {27'd0, rd_out}, 32'd0);
        dones = 0;
        busy_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busy_seen = 1'b1;
        end
        chk("midrst no done", dones, 32'd0);
        chk("midrst idle",    {31'd0, busy_seen}, 32'd0);
        run_op("after rst", 2'b01, 32'd100, 32'd7, 5'd3, 32'h0000_000E, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
